// File: rtl/ysyx_22050550_fetch_seq_pkg.sv
// ysyx_22050550_fetch_seq_pkg: shared widths, reset PC, redirect source indices and FSM encoding
package ysyx_22050550_fetch_seq_pkg;
  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
  localparam int BR = 0;
  localparam int JALR = 1;
  localparam int MRET = 2;
  localparam int TRAP = 3;
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_e;
endpackage

// File: rtl/ysyx_22050550_fetch_seq_if.sv
// ysyx_22050550_fetch_seq_if: redirect, instruction-bus and ID-side signals of the fetch sequencer
interface ysyx_22050550_fetch_seq_if;
  import ysyx_22050550_fetch_seq_pkg::*;
  logic [3:0] redir_valid;
  logic [3:0][XLEN-1:0] redir_target;
  logic [3:0] redir_grant;
  logic flush;
  logic if_req_valid;
  logic if_req_ready;
  logic [XLEN-1:0] if_req_addr;
  logic if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic inst_valid;
  logic id_ready;
  logic [31:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc;
  modport master (
    output redir_valid, redir_target, if_req_ready, if_rsp_valid, if_rsp_data, id_ready,
    input redir_grant, flush, if_req_valid, if_req_addr, inst_valid, inst, inst_pc, pc
  );
  modport slave (
    input redir_valid, redir_target, if_req_ready, if_rsp_valid, if_rsp_data, id_ready,
    output redir_grant, flush, if_req_valid, if_req_addr, inst_valid, inst, inst_pc, pc
  );
endinterface

// File: rtl/ysyx_22050550_fetch_seq_redir_arb.sv
// ysyx_22050550_redir_arb: fixed-priority redirect arbiter (trap > mret > jalr > branch) and target mux
module ysyx_22050550_redir_arb
  import ysyx_22050550_fetch_seq_pkg::*;
(
  input  logic [3:0]           redir_valid_i,
  input  logic [3:0][XLEN-1:0] redir_target_i,
  output logic [3:0]           grant_o,
  output logic                 any_o,
  output logic [XLEN-1:0]      target_o
);
  assign any_o = |redir_valid_i;
  assign grant_o = redir_valid_i[TRAP] ? 4'(1 << TRAP) :
                   redir_valid_i[MRET] ? 4'(1 << MRET) :
                   redir_valid_i[JALR] ? 4'(1 << JALR) :
                   redir_valid_i[BR]   ? 4'(1 << BR)   : 4'b0000;
  // jalr clears bit 0 of its target; others pass through unchecked
  assign target_o = redir_valid_i[TRAP] ? redir_target_i[TRAP] :
                    redir_valid_i[MRET] ? redir_target_i[MRET] :
                    redir_valid_i[JALR] ? {redir_target_i[JALR][XLEN-1:1], 1'b0} :
                    redir_target_i[BR];
endmodule

// File: rtl/ysyx_22050550_fetch_seq.sv
// ysyx_22050550_fetch_seq: fetch PC owner and instruction-bus sequencer; drains responses of fetches
// killed by a redirect so at most one bus transaction is ever outstanding.
module ysyx_22050550_fetch_seq
  import ysyx_22050550_fetch_seq_pkg::*;
(
  input logic clock,
  input logic reset,
  ysyx_22050550_fetch_seq_if.slave bus
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, tgt;
  logic [31:0] inst_q, inst_d;
  logic [3:0] grant;
  logic any, req_fire, capture;
  ysyx_22050550_redir_arb u_arb (
    .redir_valid_i (bus.redir_valid),
    .redir_target_i(bus.redir_target),
    .grant_o       (grant),
    .any_o         (any),
    .target_o      (tgt)
  );
  assign req_fire = state_q == REQ && bus.if_req_ready;
  assign capture = !any && state_q == WAIT && bus.if_rsp_valid;
  always_comb begin
    pc_d = any ? tgt : (state_q == HOLD && bus.id_ready) ? pc_q + XLEN'(4) : pc_q;
    inst_d = capture ? bus.if_rsp_data : inst_q;
    inst_pc_d = capture ? pc_q : inst_pc_q;
    state_d = state_q;
    case (state_q)
      REQ:     state_d = req_fire ? (any ? DRAIN : WAIT) : REQ;
      WAIT:    state_d = bus.if_rsp_valid ? (any ? REQ : HOLD) : (any ? DRAIN : WAIT);
      HOLD:    state_d = (any || bus.id_ready) ? REQ : HOLD;
      default: state_d = bus.if_rsp_valid ? REQ : DRAIN;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      inst_q <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end
  assign bus.redir_grant = grant;
  assign bus.flush = any;
  assign bus.if_req_valid = state_q == REQ;
  assign bus.if_req_addr = pc_q;
  assign bus.inst_valid = state_q == HOLD;
  assign bus.inst = inst_q;
  assign bus.inst_pc = inst_pc_q;
  assign bus.pc = pc_q;
  // a response is only legal while one is outstanding
  assert property (@(posedge clock) disable iff (reset)
    !(bus.if_rsp_valid && (state_q == REQ || state_q == HOLD)));
endmodule
